if_id_queue: RTL and testbench
==============================

Name: if_id_queue

Overview:
- Parametrised successor to the single-entry IF/ID pipeline register: a DEPTH-entry instruction fetch queue between fetch (pc_reg plus instruction memory) and decode.
- Decouples fetch from decode with valid/ready handshakes on both sides.
- Supports decode back-pressure (stall) and a pipeline flush for branches.
- Presents a NOP to decode whenever it is empty.

Parameters:
- ADDR_W, 32, width of instruction address (pc).
- INST_W, 32, width of instruction word.
- DEPTH, 4, number of queue entries; power of two, >= 2.
- NOP_INST, 32'h00000000, instruction word presented to ID when the queue is empty.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- flush  in  1  synchronous flush request from branch/exception logic.
- if_valid  in  1  fetch stage offers if_pc/if_inst this cycle.
- if_pc  in  ADDR_W  address of offered instruction.
- if_inst  in  INST_W  offered instruction word.
- if_ready  out  1  queue accepts an entry this cycle.
- id_ready  in  1  decode consumes head entry this cycle (0 = decode stall).
- id_valid  out  1  head entry valid.
- id_pc  out  ADDR_W  head entry address.
- id_inst  out  INST_W  head entry instruction.
- count  out  clog2(DEPTH)+1  number of occupied entries, 0..DEPTH.

Behaviour:
- Storage and pointers:
  - Circular buffer of DEPTH {pc, inst} entries.
  - Read and write pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
  - count is held in a separate register.
- Reset (rst=0, asynchronous, no clock needed):
  - pointers=0, count=0.
  - id_valid=0, id_pc=0, id_inst=NOP_INST, if_ready=0 while rst=0.
  - Storage contents need not be cleared.
- Outputs are first-word-fall-through:
  - id_valid = (count != 0).
  - id_pc/id_inst = head entry when count != 0, else 0/NOP_INST.
  - Outputs depend only on registered state; no combinational path from any input.
- if_ready = rst & ~flush & (count < DEPTH).
  - Independent of id_ready: a full queue does not accept, even if a pop happens in the same cycle.
- Push = if_valid & if_ready: write entry at wptr, wptr+1.
- Pop = id_valid & id_ready: rptr+1.
- count update:
  - push only: +1.
  - pop only: -1.
  - both: unchanged.
  - neither: unchanged.
- Latency: an entry pushed at edge N is visible on id_* (id_valid=1) immediately after edge N. This is 1 cycle fetch-to-decode, matching the old IF/ID register.
- Empty queue:
  - id_ready is ignored (no pop).
  - count never goes below 0 and rptr does not move.
- Full queue (count=DEPTH): if_ready=0; if_valid is ignored and the storage is not overwritten.
- Flush (flush=1 at an edge):
  - pointers=0, count=0, so id_valid=0 and id_inst=NOP_INST after the edge.
  - A push or pop in the same cycle is discarded; flush has priority.
  - if_ready is 0 during the flush cycle.
- Reset mid-operation: rst falling at any time clears state immediately, including mid-cycle. After rst rises, the first push is accepted at the next rising edge.
- No X on outputs after reset, regardless of storage contents.

Test Plan:
- Reset: rst=0 at t=0 with if_valid=1 -> id_valid=0, id_inst=32'h00000000, id_pc=0, count=0, if_ready=0. rst=1 at 100 ns, push pc=0x0, inst=0x00000002 -> id_valid=1, id_pc=0x0, id_inst=0x00000002 after the next edge.
- Fill and stall: id_ready=0, push pc 0x0, 0x4, 0x8, 0xC -> count=4, if_ready=0. A fifth push of pc=0x10 is ignored. Then id_ready=1 for 4 cycles -> id_pc sequence 0x0, 0x4, 0x8, 0xC, then id_valid=0 and id_inst=NOP.
- Streaming: if_valid=1 and id_ready=1 continuously with pc incrementing by 4 -> count stays at 1 and id_pc lags if_pc by exactly 1 cycle. Run 10 pushes to exercise pointer wrap past 3 -> 0.
- Simultaneous push and pop when full (count=4) -> pop occurs, push refused, count=3 next cycle. When count=2, push and pop together -> count stays 2 and order is preserved.
- Flush: with count=3, assert flush together with if_valid=1 and id_ready=1 -> next cycle count=0, id_valid=0, id_inst=NOP. The following push of pc=0x100 appears as id_pc=0x100.
- Asynchronous reset mid-operation: with count=2, drive rst=0 between clock edges -> count=0 and id_valid=0 immediately, without waiting for an edge.

Source files
------------

// File: rtl/if_id_queue.sv
// if_id_queue: DEPTH-entry first-word-fall-through instruction queue between fetch and decode.
// Revision: 1.0 - initial release.
`default_nettype none

module if_id_queue #(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [INST_W-1:0] NOP_INST = 32'h00000000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     if_valid,
  input  logic [ADDR_W-1:0]        if_pc,
  input  logic [INST_W-1:0]        if_inst,
  output logic                     if_ready,
  input  logic                     id_ready,
  output logic                     id_valid,
  output logic [ADDR_W-1:0]        id_pc,
  output logic [INST_W-1:0]        id_inst,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int                PTR_W   = $clog2(DEPTH);
  localparam int                CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0]  c_DEPTH = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0]  c_PTR_1 = PTR_W'(1);
  localparam logic [CNT_W-1:0]  c_CNT_1 = CNT_W'(1);

  logic [ADDR_W-1:0] r_pc_mem   [DEPTH];
  logic [INST_W-1:0] r_inst_mem [DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_count;

  logic w_not_empty;
  logic w_push;
  logic w_pop;

  assign w_not_empty = (r_count != '0);
  // Readiness ignores id_ready: a full queue never accepts, even while popping.
  assign if_ready    = rst & ~flush & (r_count < c_DEPTH);
  assign w_push      = if_valid & if_ready;
  assign w_pop       = w_not_empty & id_ready & ~flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + c_PTR_1;
      if (w_pop)  r_rptr <= r_rptr + c_PTR_1;
      if (w_push && !w_pop)      r_count <= r_count + c_CNT_1;
      else if (w_pop && !w_push) r_count <= r_count - c_CNT_1;
    end
  end

  // Storage is not reset; the output mux below keeps stale contents off id_*.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_wptr]   <= if_pc;
      r_inst_mem[r_wptr] <= if_inst;
    end
  end

  assign id_valid = w_not_empty;
  assign id_pc    = w_not_empty ? r_pc_mem[r_rptr]   : '0;
  assign id_inst  = w_not_empty ? r_inst_mem[r_rptr] : NOP_INST;
  assign count    = r_count;

endmodule

`default_nettype wire

// File: tb/tb_if_id_queue.sv
// tb_if_id_queue: directed and randomized checks of if_id_queue against a queue-based reference.
// Revision: 1.0 - initial release.
`default_nettype none

module tb_if_id_queue;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_ready;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic [2:0]  count;

  int   n_total = 0;
  int   n_bad   = 0;
  ent_t q[$];

  if_id_queue #(.ADDR_W(32), .INST_W(32), .DEPTH(DEPTH), .NOP_INST(32'h00000000)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst), .if_ready(if_ready),
    .id_ready(id_ready), .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check("id_valid", 64'(id_valid), 64'(q.size() != 0));
    check("id_pc",    64'(id_pc),    (q.size() != 0) ? 64'(q[0].pc)   : 64'h0);
    check("id_inst",  64'(id_inst),  (q.size() != 0) ? 64'(q[0].inst) : 64'h0);
    check("count",    64'(count),    64'(q.size()));
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                       input logic rdy, input logic fl);
    if_valid = v;
    if_pc    = pc;
    if_inst  = inst;
    id_ready = rdy;
    flush    = fl;
  endtask

  // One clock: check if_ready ahead of the edge, advance the model at the edge, check after.
  task automatic step();
    logic exp_rdy;
    bit   do_push, do_pop;
    ent_t e;
    #1;
    exp_rdy = rst && !flush && (q.size() < DEPTH);
    check("if_ready", 64'(if_ready), 64'(exp_rdy));
    do_push = if_valid && exp_rdy;
    do_pop  = (q.size() != 0) && id_ready && !flush;
    e       = '{pc: if_pc, inst: if_inst};
    @(posedge clk);
    if (!rst || flush) q.delete();
    else begin
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back(e);
    end
    #1;
    check_outputs();
  endtask

  // Assert reset between edges and confirm state clears before any clock edge.
  task automatic mid_cycle_reset();
    #3;
    rst = 1'b0;
    #1;
    q.delete();
    check("async_count",    64'(count),    64'h0);
    check("async_id_valid", 64'(id_valid), 64'h0);
    check("async_id_inst",  64'(id_inst),  64'h0);
    check("async_if_ready", 64'(if_ready), 64'h0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    logic [31:0] pc;
    rst = 1'b0;
    drive(1'b1, 32'h0, 32'h00000002, 1'b1, 1'b0);
    #2;
    check("rst_id_valid", 64'(id_valid), 64'h0);
    check("rst_id_inst",  64'(id_inst),  64'h0);
    check("rst_id_pc",    64'(id_pc),    64'h0);
    check("rst_count",    64'(count),    64'h0);
    check("rst_if_ready", 64'(if_ready), 64'h0);
    #98;
    rst = 1'b1;

    // First push after reset release, visible immediately after the edge.
    drive(1'b1, 32'h0, 32'h00000002, 1'b0, 1'b0);
    step();
    check("first_pc",   64'(id_pc),   64'h0);
    check("first_inst", 64'(id_inst), 64'h2);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step();

    // Fill while decode stalls, then attempt an ignored fifth push.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(i * 4), 32'hA000_0000 + 32'(i), 1'b0, 1'b0);
      step();
    end
    check("full_count", 64'(count), 64'd4);
    drive(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 1'b0);
    step();
    check("full_ignored_count", 64'(count), 64'd4);
    for (int i = 0; i < 4; i++) begin
      check("drain_pc", 64'(id_pc), 64'(i * 4));
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      step();
    end
    check("drained_valid", 64'(id_valid), 64'h0);

    // Streaming with pointer wrap.
    pc = 32'h200;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, pc, $urandom, 1'b1, 1'b0);
      step();
      check("stream_count", 64'(count), 64'd1);
      check("stream_lag",   64'(id_pc), 64'(pc));
      pc += 4;
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step();

    // Push+pop when full: push refused.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h300 + 32'(i * 4), $urandom, 1'b0, 1'b0);
      step();
    end
    drive(1'b1, 32'h400, $urandom, 1'b1, 1'b0);
    step();
    check("full_pushpop_count", 64'(count), 64'd3);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step();
    drive(1'b1, 32'h404, $urandom, 1'b1, 1'b0);
    step();
    check("two_pushpop_count", 64'(count), 64'd2);

    // Flush wins over a simultaneous push and pop.
    drive(1'b1, 32'h408, $urandom, 1'b0, 1'b0);
    step();
    check("preflush_count", 64'(count), 64'd3);
    drive(1'b1, 32'h40C, $urandom, 1'b1, 1'b1);
    step();
    check("flush_count", 64'(count),   64'd0);
    check("flush_inst",  64'(id_inst), 64'h0);
    drive(1'b1, 32'h100, 32'h1234_5678, 1'b0, 1'b0);
    step();
    check("postflush_pc", 64'(id_pc), 64'h100);

    // Asynchronous reset with two entries.
    drive(1'b1, 32'h104, $urandom, 1'b0, 1'b0);
    step();
    check("prereset_count", 64'(count), 64'd2);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    mid_cycle_reset();
    drive(1'b1, 32'h500, 32'h0000_0500, 1'b0, 1'b0);
    step();
    check("postreset_pc", 64'(id_pc), 64'h500);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 99) < 60), $urandom, $urandom,
            ($urandom_range(0, 99) < 50), ($urandom_range(0, 99) < 4));
      if ($urandom_range(0, 199) == 0) mid_cycle_reset();
      else step();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
